// File: rtl/spi_daisy_pkg.sv
// Shared types and constants for the SPI daisy-chain controller.
package spi_daisy_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/spi_daisy_arb.sv
// Two-requester arbiter for the SPI daisy-chain controller.
// Define SPI_DAISY_RR_EN for round-robin; default build is fixed priority to requester 0.
module spi_daisy_arb
  import spi_daisy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

`ifdef SPI_DAISY_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // In the fixed-priority build the pointer never leaves requester 0.
  logic ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= 1'b0;
    else if (advance)
      ptr <= RR & ~ptr;
  end

  always_comb begin
    grant = 2'b00;
    if (!ptr) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

endmodule

// File: rtl/spi_daisy_ctrl.sv
// SPI mode-0 master for a chain of N_SLAVES 8-bit slaves shared by two requesters.
// Arbitration policy is selected by SPI_DAISY_RR_EN inside spi_daisy_arb.
module spi_daisy_ctrl
  import spi_daisy_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter int CLK_DIV  = 4,
  localparam int FW      = BYTE_W * N_SLAVES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [FW-1:0] tx0,
  input  logic [FW-1:0] tx1,
  output logic [1:0]    grant,
  output logic [1:0]    done,
  output logic [FW-1:0] rx_data,
  output logic          busy,
  output logic          sclk,
  output logic          cs,
  output logic          mosi,
  input  logic          miso
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FW);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_SETUP = CW'(CLK_DIV);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FW - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [FW-1:0] tx_sh;
  logic [FW-1:0] rx_sh;
  logic [1:0]    arb_grant;
  logic          arb_advance;

  assign arb_advance = (state == IDLE) && (|req);

  spi_daisy_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      grant   <= 2'b00;
      done    <= 2'b00;
      busy    <= 1'b0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
      rx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant   <= arb_grant;
            busy    <= 1'b1;
            tx_sh   <= arb_grant[1] ? tx1 : tx0;
            cnt     <= CNT_SETUP;
            bit_idx <= '0;
            state   <= SETUP;
          end
        end
        // First SETUP cycle lowers cs; CLK_DIV more cycles of setup follow.
        SETUP: begin
          cs   <= 1'b0;
          mosi <= tx_sh[0];
          if (cnt == '0) begin
            state <= SHIFT;
            sclk  <= 1'b1;
            cnt   <= CNT_HALF;
            rx_sh <= {miso, rx_sh[FW-1:1]};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (sclk) begin
            sclk <= 1'b0;
            cnt  <= CNT_HALF;
            if (bit_idx != LAST_BIT) begin
              mosi  <= tx_sh[1];
              tx_sh <= tx_sh >> 1;
            end
          end else if (bit_idx == LAST_BIT) begin
            state <= HOLD;
            cnt   <= CNT_HALF;
          end else begin
            sclk    <= 1'b1;
            cnt     <= CNT_HALF;
            bit_idx <= bit_idx + 1'b1;
            rx_sh   <= {miso, rx_sh[FW-1:1]};
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state   <= DONE;
            cs      <= 1'b1;
            mosi    <= 1'b0;
            done    <= grant;
            rx_data <= rx_sh;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 2'b00;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_daisy_ctrl.sv
// Self-checking bench for spi_daisy_ctrl: directed frames, daisy-chain slave model, random traffic.
module tb_spi_daisy_ctrl;

  localparam int N_SLAVES = 2;
  localparam int CLK_DIV  = 4;
  localparam int FW       = 8 * N_SLAVES;
  localparam int FRAME_CS = CLK_DIV * (2 * FW + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [FW-1:0] tx0, tx1;
  logic [1:0]    grant, done;
  logic [FW-1:0] rx_data;
  logic          busy, sclk, cs, mosi, miso;

  always #5 clk = ~clk;

  spi_daisy_ctrl #(.N_SLAVES(N_SLAVES), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .req(req), .tx0(tx0), .tx1(tx1),
    .grant(grant), .done(done), .rx_data(rx_data), .busy(busy),
    .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
  );

  // Slave chain: each slave shifts mosi in on sclk rising, last slave drives miso.
  logic          loopback = 1'b1;
  logic          chain_clr = 1'b0;
  logic [FW-1:0] chain;
  assign miso = loopback ? mosi : chain[0];

  always @(posedge sclk or posedge chain_clr) begin
    if (chain_clr) chain <= '0;
    else           chain <= {mosi, chain[FW-1:1]};
  end

  int checks = 0, errors = 0;
  int cs_low_cnt = 0, rise_cnt = 0, done_cnt = 0, viol_cnt = 0;

  always @(posedge clk) begin
    if (!cs) cs_low_cnt <= cs_low_cnt + 1;
    if (|done) done_cnt <= done_cnt + 1;
    if (!rst && cs && (sclk || mosi)) viol_cnt <= viol_cnt + 1;
  end
  always @(posedge sclk) rise_cnt <= rise_cnt + 1;

  logic          model_ptr = 1'b0;
  logic [FW-1:0] model_chain = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_grant(input logic [1:0] r);
`ifdef SPI_DAISY_RR_EN
    if (r == 2'b11) return model_ptr ? 2'b10 : 2'b01;
`else
    if (r == 2'b11) return 2'b01;
`endif
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 1'b0;
  endtask

  task automatic clear_chain();
    chain_clr = 1'b1;
    #1;
    chain_clr = 1'b0;
    model_chain = '0;
  endtask

  // One complete frame; returns the observed grant.
  task automatic run_frame(input logic [1:0] r, input bit drop, input bit late1,
                           input bit chain_mode, output logic [1:0] g_obs);
    logic [1:0]    exp_g;
    logic [FW-1:0] exp_tx, exp_rx;
    int            cs0, r0, d0;
    bit            got;
    @(negedge clk);
    req = r;
    loopback = !chain_mode;
    exp_g  = model_grant(r);
    exp_tx = exp_g[1] ? tx1 : tx0;
    cs0 = cs_low_cnt; r0 = rise_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    model_ptr = ~model_ptr;
    g_obs = grant;
    chk("grant", 64'(grant), 64'(exp_g));
    chk("busy_at_grant", 64'(busy), 64'(1));
    chk("cs_high_at_grant", 64'(cs), 64'(1));
    tx0 = FW'($urandom);
    tx1 = FW'($urandom);
    @(posedge clk); #1;
    chk("cs_low_latency", 64'(cs), 64'(0));
    if (late1) begin
      repeat (20) @(posedge clk);
      #1;
      req[1] = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 4 * FRAME_CS && !got; i++) begin
      @(posedge clk); #1;
      if (done != 2'b00) got = 1'b1;
    end
    chk("done_seen", 64'(got), 64'(1));
    exp_rx = chain_mode ? model_chain : exp_tx;
    model_chain = exp_tx;
    chk("done_owner", 64'(done), 64'(exp_g));
    chk("rx_data", 64'(rx_data), 64'(exp_rx));
    chk("cs_high_in_done", 64'(cs), 64'(1));
    chk("busy_in_done", 64'(busy), 64'(1));
    @(negedge clk);
    if (drop) req = req & ~exp_g;
    @(posedge clk); #1;
    chk("done_one_clk", 64'(done), 64'(0));
    chk("busy_clear", 64'(busy), 64'(0));
    chk("grant_clear", 64'(grant), 64'(0));
    chk("cs_low_cycles", 64'(cs_low_cnt - cs0), 64'(FRAME_CS));
    chk("sclk_rises", 64'(rise_cnt - r0), 64'(FW));
    chk("done_pulses", 64'(done_cnt - d0), 64'(1));
    chk("rx_hold", 64'(rx_data), 64'(exp_rx));
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] g;
    logic [1:0] seq [4];
    logic [1:0] exp_seq [4];
    int r0, d0;
    logic [1:0] rr;

    rst = 1'b1; req = 2'b00; tx0 = '0; tx1 = '0;
    clear_chain();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", 64'(cs), 64'(1));
    chk("rst_sclk", 64'(sclk), 64'(0));
    chk("rst_mosi", 64'(mosi), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rx", 64'(rx_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Loopback frame
    tx0 = 16'hA53C;
    run_frame(2'b01, 1'b1, 1'b0, 1'b0, g);
    chk("loop_rx_a53c", 64'(rx_data), 64'h0000_0000_0000_A53C);

    // Two-slave chain: first frame returns reset contents, second returns first frame's data
    clear_chain();
    tx0 = 16'h1234;
    run_frame(2'b01, 1'b1, 1'b0, 1'b1, g);
    chk("chain_rx_0000", 64'(rx_data), 64'h0);
    tx0 = 16'hBEEF;
    run_frame(2'b01, 1'b1, 1'b0, 1'b1, g);
    chk("chain_rx_1234", 64'(rx_data), 64'h1234);

    // Both requesters held for four frames
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_frame(2'b11, (i == 3), 1'b0, 1'b0, g);
      seq[i] = g;
`ifdef SPI_DAISY_RR_EN
      exp_seq[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_seq[i] = 2'b01;
`endif
    end
    for (int i = 0; i < 4; i++) chk("arb_sequence", 64'(seq[i]), 64'(exp_seq[i]));
    @(negedge clk);
    req = 2'b00;

    // Requester 1 rises mid-frame and is served right after IDLE is re-entered
    run_frame(2'b01, 1'b1, 1'b1, 1'b0, g);
    chk("late_req_pending", 64'(req), 64'(2'b10));
    run_frame(2'b10, 1'b1, 1'b0, 1'b0, g);

    // Reset at the fifth sclk rising edge
    @(negedge clk);
    req = 2'b01; loopback = 1'b1;
    r0 = rise_cnt; d0 = done_cnt;
    for (int i = 0; i < 400 && (rise_cnt - r0) < 5; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_rise5", 64'(rise_cnt - r0), 64'(5));
    rst = 1'b1;
    #1;
    chk("rst_mid_cs", 64'(cs), 64'(1));
    chk("rst_mid_sclk", 64'(sclk), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_grant", 64'(grant), 64'(0));
    chk("rst_mid_rx", 64'(rx_data), 64'(0));
    req = 2'b00;
    model_ptr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'(0));
    clear_chain();
    run_frame(2'b01, 1'b1, 1'b0, 1'b0, g);

    // Random traffic
    for (int i = 0; i < 12; i++) begin
      rr  = 2'($urandom_range(1, 3));
      tx0 = FW'($urandom);
      tx1 = FW'($urandom);
      run_frame(rr, ($urandom_range(0, 1) == 1), 1'b0, ($urandom_range(0, 1) == 1), g);
    end
    @(negedge clk);
    req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_outputs_quiet", 64'(viol_cnt), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
